// File: rtl/id_ex_pipe.sv
// Purpose : ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Latency : one cycle from id_* to ex_*; stall and pc_write are combinational.
// Backpres: stall holds PC and IF/ID for one cycle while a bubble enters EX; flush squashes ID.
//
// Ports:
//   clk, reset (synchronous, active-high), flush (squash the ID-stage instruction)
//   id_*  : decode controls (RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst,
//           ALUSrc, ALUOp[3:0], Jump[1:0]), operands rd1/rd2/imm/pc4 [31:0],
//           fields rs/rt/rd/shamt [4:0]
//   ex_*  : registered copies of every id_* input
//   stall, pc_write : load-use hazard indication and its complement
//   bubble_count    : saturating count of inserted bubbles
//
// Optional feature: define ID_EX_HAZARD_DETECT_EN to enable load-use detection and the
// bubble counter. Without it stall is 0, pc_write is 1 and bubble_count is 0.
module id_ex_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        id_RegWrite,
  input  logic        id_MemToReg,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        id_Branch,
  input  logic        id_RegDst,
  input  logic        id_ALUSrc,
  input  logic [3:0]  id_ALUOp,
  input  logic [1:0]  id_Jump,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc4,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_shamt,
  output logic        ex_RegWrite,
  output logic        ex_MemToReg,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_Branch,
  output logic        ex_RegDst,
  output logic        ex_ALUSrc,
  output logic [3:0]  ex_ALUOp,
  output logic [1:0]  ex_Jump,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc4,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_shamt,
  output logic        stall,
  output logic        pc_write,
  output logic [15:0] bubble_count
);

  // A squashed or stalled slot keeps its datapath fields but carries no controls,
  // so it behaves as a NOP in the later stages.
  logic kill_ctrl;
  assign kill_ctrl = flush | stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_RegWrite <= 1'b0;
      ex_MemToReg <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_RegDst   <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOp    <= 4'd0;
      ex_Jump     <= 2'd0;
      ex_rd1      <= 32'd0;
      ex_rd2      <= 32'd0;
      ex_imm      <= 32'd0;
      ex_pc4      <= 32'd0;
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
      ex_shamt    <= 5'd0;
    end else begin
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_pc4   <= id_pc4;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_shamt <= id_shamt;
      if (kill_ctrl) begin
        ex_RegWrite <= 1'b0;
        ex_MemToReg <= 1'b0;
        ex_MemRead  <= 1'b0;
        ex_MemWrite <= 1'b0;
        ex_Branch   <= 1'b0;
        ex_RegDst   <= 1'b0;
        ex_ALUSrc   <= 1'b0;
        ex_ALUOp    <= 4'd0;
        ex_Jump     <= 2'd0;
      end else begin
        ex_RegWrite <= id_RegWrite;
        ex_MemToReg <= id_MemToReg;
        ex_MemRead  <= id_MemRead;
        ex_MemWrite <= id_MemWrite;
        ex_Branch   <= id_Branch;
        ex_RegDst   <= id_RegDst;
        ex_ALUSrc   <= id_ALUSrc;
        ex_ALUOp    <= id_ALUOp;
        ex_Jump     <= id_Jump;
      end
    end
  end

`ifdef ID_EX_HAZARD_DETECT_EN
  // Load in EX whose destination is a source of the ID instruction. $zero never
  // creates a dependency. Only registered EX state and ID fields feed this term,
  // so flush has no path into stall. The bubble clears ex_MemRead, which
  // guarantees the stall lasts exactly one cycle.
  assign stall = ex_MemRead && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Flush takes priority over a stall, so a squashed slot is not counted as a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= 16'd0;
    end else if (stall && !flush && (bubble_count != 16'hFFFF)) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end
`else
  assign stall        = 1'b0;
  assign bubble_count = 16'd0;
`endif

  assign pc_write = ~stall;

endmodule
